// File: rtl/apb_to_ahbl.sv
// rtl/apb_to_ahbl.sv - APB completer replaying each transfer as one AHB-Lite NONSEQ word access
module apb_to_ahbl #(
    parameter int                  W_PADDR    = 16,
    parameter int                  W_HADDR    = 32,
    parameter int                  W_DATA     = 32,
    parameter logic [W_HADDR-1:0]  HADDR_BASE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               apbs_psel,
    input  logic               apbs_penable,
    input  logic               apbs_pwrite,
    input  logic [W_PADDR-1:0] apbs_paddr,
    input  logic [W_DATA-1:0]  apbs_pwdata,
    output logic               apbs_pready,
    output logic [W_DATA-1:0]  apbs_prdata,
    output logic               apbs_pslverr,
    output logic [W_HADDR-1:0] ahblm_haddr,
    output logic               ahblm_hwrite,
    output logic [1:0]         ahblm_htrans,
    output logic [2:0]         ahblm_hsize,
    output logic [2:0]         ahblm_hburst,
    output logic [3:0]         ahblm_hprot,
    output logic               ahblm_hmastlock,
    output logic [W_DATA-1:0]  ahblm_hwdata,
    input  logic               ahblm_hready,
    input  logic               ahblm_hresp,
    input  logic [W_DATA-1:0]  ahblm_hrdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_APH  = 2'd1,
        S_DPH  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [W_HADDR-1:0]  haddr_q, haddr_d;
    logic                hwrite_q;
    logic [W_DATA-1:0]   hwdata_q;
    logic [W_DATA-1:0]   prdata_q;
    logic                pslverr_q;
    logic                setup;

    // Only a setup phase starts a transfer; an access phase seen in idle is ignored.
    assign setup = apbs_psel & ~apbs_penable;

    always_comb begin
        haddr_d                = HADDR_BASE;
        haddr_d[W_PADDR-1:0]   = apbs_paddr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (setup)        state_d = S_APH;
            S_APH:   if (ahblm_hready) state_d = S_DPH;
            S_DPH:   if (ahblm_hready) state_d = S_RESP;
            S_RESP:                    state_d = S_IDLE;
            default:                   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ahblm_htrans = 2'b00;
        apbs_pready  = 1'b0;
        apbs_pslverr = 1'b0;
        case (state_q)
            S_APH:  ahblm_htrans = 2'b10;
            S_RESP: begin
                apbs_pready  = 1'b1;
                apbs_pslverr = pslverr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            haddr_q   <= '0;
            hwrite_q  <= 1'b0;
            hwdata_q  <= '0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && setup) begin
                haddr_q  <= haddr_d;
                hwrite_q <= apbs_pwrite;
                hwdata_q <= apbs_pwdata;
            end
            // prdata keeps the last read value across writes.
            if (state_q == S_DPH && ahblm_hready) begin
                if (!hwrite_q) begin
                    prdata_q <= ahblm_hrdata;
                end
                pslverr_q <= ahblm_hresp;
            end
        end
    end

    assign apbs_prdata     = prdata_q;
    assign ahblm_haddr     = haddr_q;
    assign ahblm_hwrite    = hwrite_q;
    assign ahblm_hwdata    = hwdata_q;
    assign ahblm_hsize     = 3'b010;
    assign ahblm_hburst    = 3'b000;
    assign ahblm_hprot     = 4'b0011;
    assign ahblm_hmastlock = 1'b0;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// tb/tb_apb_to_ahbl.sv - directed table-driven bench for apb_to_ahbl
module tb_apb_to_ahbl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hwrite, hmastlock, hready, hresp;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;

    int ntests = 0;
    int nfail  = 0;

    localparam logic [31:0] BASE = 32'h4000_0000;

    apb_to_ahbl #(
        .W_PADDR(16), .W_HADDR(32), .W_DATA(32), .HADDR_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .apbs_psel(psel), .apbs_penable(penable), .apbs_pwrite(pwrite),
        .apbs_paddr(paddr), .apbs_pwdata(pwdata),
        .apbs_pready(pready), .apbs_prdata(prdata), .apbs_pslverr(pslverr),
        .ahblm_haddr(haddr), .ahblm_hwrite(hwrite), .ahblm_htrans(htrans),
        .ahblm_hsize(hsize), .ahblm_hburst(hburst), .ahblm_hprot(hprot),
        .ahblm_hmastlock(hmastlock), .ahblm_hwdata(hwdata),
        .ahblm_hready(hready), .ahblm_hresp(hresp), .ahblm_hrdata(hrdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        b2b;
        logic        wr;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        resp;
        int          aw;
        int          dw;
        logic [31:0] exp_prdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
    endtask

    // Called at posedge+1 of the setup cycle; returns at posedge+1 of the cycle after pready.
    task automatic run_xfer(input vec_t v);
        int total;
        logic [31:0] exp_haddr;
        exp_haddr = BASE | {16'h0, v.addr};
        total = v.aw + v.dw + 2;
        psel = 1'b1; penable = 1'b0; pwrite = v.wr; paddr = v.addr; pwdata = v.wdata;
        hready = 1'b1; hresp = 1'b0; hrdata = 32'hBAD0_0000;
        #3;
        chk("setup_htrans", {30'h0, htrans}, 32'h0);
        chk("setup_pready", {31'h0, pready}, 32'h0);
        step();
        penable = 1'b1;
        for (int k = 1; k <= total + 1; k++) begin
            if (k <= v.aw + 1) begin
                hready = (k <= v.aw) ? 1'b0 : 1'b1;
                hresp  = 1'b0;
                hrdata = 32'hBAD0_0000 + k;
                #3;
                chk("aph_htrans", {30'h0, htrans}, 32'h2);
                chk("aph_haddr", haddr, exp_haddr);
                chk("aph_hwrite", {31'h0, hwrite}, {31'h0, v.wr});
                chk("aph_pready", {31'h0, pready}, 32'h0);
            end else if (k <= total) begin
                hready = (k < total) ? 1'b0 : 1'b1;
                hresp  = v.resp & (k >= total - 1);
                hrdata = (k == total) ? v.rdata : 32'hBAD0_0000 + k;
                #3;
                chk("dph_htrans", {30'h0, htrans}, 32'h0);
                if (v.wr) chk("dph_hwdata", hwdata, v.wdata);
                chk("dph_haddr", haddr, exp_haddr);
                chk("dph_pready", {31'h0, pready}, 32'h0);
            end else begin
                hready = 1'b1; hresp = 1'b0; hrdata = 32'hBAD0_FFFF;
                #3;
                chk("resp_pready", {31'h0, pready}, 32'h1);
                chk("resp_pslverr", {31'h0, pslverr}, {31'h0, v.exp_err});
                chk("resp_prdata", prdata, v.exp_prdata);
                chk("resp_htrans", {30'h0, htrans}, 32'h0);
            end
            step();
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 16'h0040, 32'h0,          32'hDEADBEEF, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 16'h0044, 32'h12345678,   32'h0BAD0BAD, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 16'h1230, 32'hA5A55A5A,   32'h0BAD0BAD, 1'b0, 2, 3, 32'hDEADBEEF, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 16'hFFFC, 32'h0,          32'h0F1E2D3C, 1'b0, 2, 3, 32'h0F1E2D3C, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 16'h0008, 32'h0,          32'h11112222, 1'b1, 0, 1, 32'h11112222, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 16'h000C, 32'h0,          32'h55667788, 1'b0, 0, 0, 32'h55667788, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 16'h0010, 32'hCAFEF00D,   32'h0BAD0BAD, 1'b1, 1, 1, 32'h55667788, 1'b1};
        vecs[7] = '{1'b1, 1'b0, 16'h0014, 32'h0,          32'h89ABCDEF, 1'b0, 0, 0, 32'h89ABCDEF, 1'b0};

        rst_n = 1'b0;
        paddr = 16'h0; pwdata = 32'h0;
        idle_bus();
        repeat (3) step();
        chk("rst_htrans", {30'h0, htrans}, 32'h0);
        chk("rst_haddr", haddr, 32'h0);
        chk("rst_hwrite", {31'h0, hwrite}, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pready", {31'h0, pready}, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("const_ctrl", {20'h0, hsize, hburst, hprot, 1'b0, hmastlock}, {20'h0, 3'b010, 3'b000, 4'b0011, 2'b00});
        rst_n = 1'b1;
        step();

        // Access phase without a preceding setup must be ignored.
        psel = 1'b1; penable = 1'b1; paddr = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("nosetup_htrans", {30'h0, htrans}, 32'h0);
            chk("nosetup_pready", {31'h0, pready}, 32'h0);
            step();
        end
        idle_bus();
        step();

        for (int i = 0; i < 8; i++) begin
            if (!vecs[i].b2b) begin
                idle_bus();
                step();
            end
            run_xfer(vecs[i]);
        end
        idle_bus();
        #3;
        chk("post_pready", {31'h0, pready}, 32'h0);
        chk("post_pslverr", {31'h0, pslverr}, 32'h0);
        step();

        // Reset asserted while the bridge sits in the data phase.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0100;
        step();
        penable = 1'b1; hready = 1'b1;
        #3;
        chk("rstdph_aph", {30'h0, htrans}, 32'h2);
        step();
        hready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstdph_htrans", {30'h0, htrans}, 32'h0);
        chk("rstdph_pready", {31'h0, pready}, 32'h0);
        chk("rstdph_prdata", prdata, 32'h0);
        chk("rstdph_haddr", haddr, 32'h0);
        idle_bus();
        step();
        step();
        chk("rstdph_hold_htrans", {30'h0, htrans}, 32'h0);
        rst_n = 1'b1;
        step();
        run_xfer('{1'b0, 1'b0, 16'h0200, 32'h0, 32'h13579BDF, 1'b0, 0, 0, 32'h13579BDF, 1'b0});
        idle_bus();
        step();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
